hazard_tracker: RTL and testbench

//  Consumer side of the D-stage decode bundle: takes per-instruction register-use times
//  (rs_use/rt_use, Tuse) and destination/result times (dst_addr/dst_save, Tnew).

---
 rtl/hazard_pkg.sv | 31 +++
 rtl/hazard_src_match.sv | 39 +++
 rtl/hazard_tracker.sv | 107 ++++++++++
 tb/tb_hazard_tracker.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types, codes and helpers for the hazard tracker
package hazard_pkg;
    localparam int REG_AW = 5;
    localparam int TIME_W = 4;

    localparam logic [TIME_W-1:0] TUSE_NONE = 4'hF;

    typedef enum logic [1:0] {
        FWD_GRF = 2'd0,
        FWD_E   = 2'd1,
        FWD_M   = 2'd2,
        FWD_W   = 2'd3
    } fwd_sel_e;

    typedef struct packed {
        logic              wr;
        logic [REG_AW-1:0] addr;
        logic [TIME_W-1:0] tnew;
    } hazard_rec_t;

    function automatic logic [TIME_W-1:0] sat_dec(input logic [TIME_W-1:0] v);
        return (v == '0) ? '0 : v - 1'b1;
    endfunction

    function automatic hazard_rec_t age_rec(input hazard_rec_t r);
        hazard_rec_t o;
        o      = r;
        o.tnew = sat_dec(r.tnew);
        return o;
    endfunction
endpackage

// File: rtl/hazard_src_match.sv
// rtl/hazard_src_match.sv - nearest-producer match, stall and forward select for one source
module hazard_src_match
    import hazard_pkg::*;
(
    input  logic [REG_AW-1:0] src_addr,
    input  logic [TIME_W-1:0] src_use,
    input  hazard_rec_t       rec_e,
    input  hazard_rec_t       rec_m,
    input  hazard_rec_t       rec_w,
    output logic              stall_s,
    output logic [1:0]        fwd_s
);
    logic              found;
    logic [TIME_W-1:0] hit_tnew;
    logic [1:0]        hit_code;

    function automatic logic hit(input hazard_rec_t r, input logic [REG_AW-1:0] a);
        return r.wr && (r.addr == a) && (a != '0);
    endfunction

    // Nearest stage wins; older writers of the same register are shadowed.
    always_comb begin
        found    = 1'b0;
        hit_tnew = '0;
        hit_code = FWD_GRF;
        if (src_use != TUSE_NONE) begin
            if (hit(rec_e, src_addr)) begin
                found = 1'b1; hit_tnew = rec_e.tnew; hit_code = FWD_E;
            end else if (hit(rec_m, src_addr)) begin
                found = 1'b1; hit_tnew = rec_m.tnew; hit_code = FWD_M;
            end else if (hit(rec_w, src_addr)) begin
                found = 1'b1; hit_tnew = rec_w.tnew; hit_code = FWD_W;
            end
        end
        stall_s = found && (hit_tnew > src_use);
        // A producer that is ready by the consumer's use time is forwarded from its stage.
        fwd_s   = (found && !stall_s) ? hit_code : FWD_GRF;
    end
endmodule

// File: rtl/hazard_tracker.sv
// rtl/hazard_tracker.sv - E/M/W scoreboard driving stall, D-stage forwarding and a stall counter
// Optional MDU busy tracking is built when HAZARD_TRACKER_MDU_EN is defined.
module hazard_tracker
    import hazard_pkg::*;
#(
    parameter int MDU_MUL_LAT = 5,
    parameter int MDU_DIV_LAT = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_rs_addr,
    input  logic [REG_AW-1:0] d_rt_addr,
    input  logic [TIME_W-1:0] d_rs_use,
    input  logic [TIME_W-1:0] d_rt_use,
    input  logic              d_reg_write,
    input  logic [REG_AW-1:0] d_dst_addr,
    input  logic [TIME_W-1:0] d_dst_save,
    input  logic              d_md_use,
    input  logic              e_md_start,
    input  logic              e_md_is_div,
    output logic              stall,
    output logic [1:0]        fwd_rs,
    output logic [1:0]        fwd_rt,
    output logic [31:0]       stall_cnt
);
    hazard_rec_t rec_e_q, rec_m_q, rec_w_q;
    hazard_rec_t rec_e_d, rec_m_d, rec_w_d;
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [TIME_W-1:0] rs_use_g, rt_use_g;
    logic stall_rs, stall_rt, stall_mdu;

    // An invalid D slot is treated as reading nothing.
    assign rs_use_g = d_valid ? d_rs_use : TUSE_NONE;
    assign rt_use_g = d_valid ? d_rt_use : TUSE_NONE;

    hazard_src_match u_match_rs (
        .src_addr (d_rs_addr),
        .src_use  (rs_use_g),
        .rec_e    (rec_e_q),
        .rec_m    (rec_m_q),
        .rec_w    (rec_w_q),
        .stall_s  (stall_rs),
        .fwd_s    (fwd_rs)
    );

    hazard_src_match u_match_rt (
        .src_addr (d_rt_addr),
        .src_use  (rt_use_g),
        .rec_e    (rec_e_q),
        .rec_m    (rec_m_q),
        .rec_w    (rec_w_q),
        .stall_s  (stall_rt),
        .fwd_s    (fwd_rt)
    );

`ifdef HAZARD_TRACKER_MDU_EN
    logic [7:0] mdu_busy_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mdu_busy_q <= '0;
        end else if (e_md_start) begin
            mdu_busy_q <= e_md_is_div ? 8'(MDU_DIV_LAT) : 8'(MDU_MUL_LAT);
        end else if (mdu_busy_q != '0) begin
            mdu_busy_q <= mdu_busy_q - 8'd1;
        end
    end

    assign stall_mdu = d_valid & d_md_use & (e_md_start | (mdu_busy_q != '0));
`else
    logic unused_mdu;
    assign unused_mdu = ^{d_md_use, e_md_start, e_md_is_div};
    assign stall_mdu  = 1'b0;
`endif

    assign stall = stall_rs | stall_rt | stall_mdu;

    always_comb begin
        rec_e_d = '0;
        if (!stall) begin
            rec_e_d.wr   = d_valid & d_reg_write & (d_dst_addr != '0);
            rec_e_d.addr = d_dst_addr;
            rec_e_d.tnew = d_dst_save;
        end
    end

    assign rec_m_d     = age_rec(rec_e_q);
    assign rec_w_d     = age_rec(rec_m_q);
    assign stall_cnt_d = (stall && (stall_cnt_q != '1)) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rec_e_q     <= '0;
            rec_m_q     <= '0;
            rec_w_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            rec_e_q     <= rec_e_d;
            rec_m_q     <= rec_m_d;
            rec_w_q     <= rec_w_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
endmodule

// File: tb/tb_hazard_tracker.sv
// tb/tb_hazard_tracker.sv - directed self-checking bench for hazard_tracker
module tb_hazard_tracker;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        d_valid;
    logic [4:0]  d_rs_addr, d_rt_addr, d_dst_addr;
    logic [3:0]  d_rs_use, d_rt_use, d_dst_save;
    logic        d_reg_write, d_md_use, e_md_start, e_md_is_div;
    logic        stall;
    logic [1:0]  fwd_rs, fwd_rt;
    logic [31:0] stall_cnt;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef HAZARD_TRACKER_MDU_EN
    localparam int EXP_MDU_START = 1;
    localparam int EXP_MDU_AFTER = 10;
`else
    localparam int EXP_MDU_START = 0;
    localparam int EXP_MDU_AFTER = 0;
`endif

    always #5 clk = ~clk;

    hazard_tracker dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .d_valid     (d_valid),
        .d_rs_addr   (d_rs_addr),
        .d_rt_addr   (d_rt_addr),
        .d_rs_use    (d_rs_use),
        .d_rt_use    (d_rt_use),
        .d_reg_write (d_reg_write),
        .d_dst_addr  (d_dst_addr),
        .d_dst_save  (d_dst_save),
        .d_md_use    (d_md_use),
        .e_md_start  (e_md_start),
        .e_md_is_div (e_md_is_div),
        .stall       (stall),
        .fwd_rs      (fwd_rs),
        .fwd_rt      (fwd_rt),
        .stall_cnt   (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_d(input logic v, input logic [4:0] rs, input logic [3:0] rsu,
                         input logic [4:0] rt, input logic [3:0] rtu,
                         input logic rw, input logic [4:0] dst, input logic [3:0] save);
        d_valid = v;  d_rs_addr = rs; d_rs_use = rsu; d_rt_addr = rt; d_rt_use = rtu;
        d_reg_write = rw; d_dst_addr = dst; d_dst_save = save;
    endtask

    task automatic nop();
        set_d(1'b0, 5'd0, 4'hF, 5'd0, 4'hF, 1'b0, 5'd0, 4'd0);
        d_md_use = 1'b0; e_md_start = 1'b0; e_md_is_div = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drain();
        nop();
        repeat (3) tick();
    endtask

    int mdu_after;

    initial begin
        reset_n = 1'b0;
        nop();
        settle();
        check_eq("rst_stall", {31'd0, stall}, 32'd0);
        check_eq("rst_fwd", {28'd0, fwd_rs, fwd_rt}, 32'd0);
        check_eq("rst_cnt", stall_cnt, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // 1: lw $8 (Tnew 2) then addu $9,$8,$8 (Tuse 1)
        set_d(1'b1, 5'd1, 4'd1, 5'd0, 4'hF, 1'b1, 5'd8, 4'd2);
        tick();
        set_d(1'b1, 5'd8, 4'd1, 5'd8, 4'd1, 1'b1, 5'd9, 4'd1);
        settle();
        check_eq("t1_stall", {31'd0, stall}, 32'd1);
        tick();
        settle();
        check_eq("t1_release", {31'd0, stall}, 32'd0);
        check_eq("t1_fwd_rs", {30'd0, fwd_rs}, 32'd2);
        check_eq("t1_fwd_rt", {30'd0, fwd_rt}, 32'd2);
        check_eq("t1_cnt", stall_cnt, 32'd1);
        tick();
        drain();

        // 2a: addu $8 (Tnew 1) then beq $8 (Tuse 0)
        set_d(1'b1, 5'd2, 4'd1, 5'd3, 4'd1, 1'b1, 5'd8, 4'd1);
        tick();
        set_d(1'b1, 5'd8, 4'd0, 5'd0, 4'd0, 1'b0, 5'd0, 4'd0);
        settle();
        check_eq("t2_beq_stall", {31'd0, stall}, 32'd1);
        check_eq("t2_beq_fwd_hold", {30'd0, fwd_rs}, 32'd0);
        tick();
        settle();
        check_eq("t2_beq_release", {31'd0, stall}, 32'd0);
        check_eq("t2_beq_fwd", {30'd0, fwd_rs}, 32'd2);
        check_eq("t2_cnt", stall_cnt, 32'd2);
        tick();
        drain();

        // 2b: addu $8 (Tnew 1) then addu using $8 (Tuse 1)
        set_d(1'b1, 5'd2, 4'd1, 5'd3, 4'd1, 1'b1, 5'd8, 4'd1);
        tick();
        set_d(1'b1, 5'd4, 4'd1, 5'd8, 4'd1, 1'b1, 5'd10, 4'd1);
        settle();
        check_eq("t2_alu_stall", {31'd0, stall}, 32'd0);
        check_eq("t2_alu_fwd_rt", {30'd0, fwd_rt}, 32'd1);
        check_eq("t2_alu_fwd_rs", {30'd0, fwd_rs}, 32'd0);
        tick();
        drain();

        // 3: $5 written in W (tnew 0) and E (tnew 1); D reads $5 with Tuse 1
        set_d(1'b1, 5'd0, 4'hF, 5'd0, 4'hF, 1'b1, 5'd5, 4'd1);
        tick();
        nop();
        tick();
        set_d(1'b1, 5'd0, 4'hF, 5'd0, 4'hF, 1'b1, 5'd5, 4'd1);
        tick();
        set_d(1'b1, 5'd5, 4'd1, 5'd0, 4'hF, 1'b0, 5'd0, 4'd0);
        settle();
        check_eq("t3_prio_stall", {31'd0, stall}, 32'd0);
        check_eq("t3_prio_fwd", {30'd0, fwd_rs}, 32'd1);
        tick();
        settle();
        check_eq("t3_next_fwd", {30'd0, fwd_rs}, 32'd2);
        tick();
        drain();

        // 4: $0 destination/source and unused rt; invalid D ignores a live hazard
        set_d(1'b1, 5'd0, 4'hF, 5'd0, 4'hF, 1'b1, 5'd0, 4'd2);
        tick();
        set_d(1'b1, 5'd0, 4'd0, 5'd0, 4'hF, 1'b0, 5'd0, 4'd0);
        settle();
        check_eq("t4_zero_stall", {31'd0, stall}, 32'd0);
        check_eq("t4_zero_fwd", {28'd0, fwd_rs, fwd_rt}, 32'd0);
        tick();
        set_d(1'b1, 5'd0, 4'hF, 5'd0, 4'hF, 1'b1, 5'd8, 4'd2);
        tick();
        set_d(1'b0, 5'd8, 4'd0, 5'd8, 4'd0, 1'b0, 5'd0, 4'd0);
        settle();
        check_eq("t4_invalid_stall", {31'd0, stall}, 32'd0);
        check_eq("t4_invalid_fwd", {28'd0, fwd_rs, fwd_rt}, 32'd0);
        tick();
        drain();

        // 5: reset asserted during a load-use stall
        set_d(1'b1, 5'd1, 4'd1, 5'd0, 4'hF, 1'b1, 5'd8, 4'd2);
        tick();
        set_d(1'b1, 5'd8, 4'd1, 5'd8, 4'd1, 1'b1, 5'd9, 4'd1);
        settle();
        check_eq("t5_pre_stall", {31'd0, stall}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        check_eq("t5_rst_stall", {31'd0, stall}, 32'd0);
        check_eq("t5_rst_fwd", {28'd0, fwd_rs, fwd_rt}, 32'd0);
        check_eq("t5_rst_cnt", stall_cnt, 32'd0);
        tick();
        reset_n = 1'b1;
        drain();
        settle();
        check_eq("t5_post_cnt", stall_cnt, 32'd0);
        tick();

        // 6: div starts in E while mflo sits in D
        nop();
        d_valid = 1'b1; d_md_use = 1'b1; e_md_start = 1'b1; e_md_is_div = 1'b1;
        settle();
        check_eq("t6_start_stall", {31'd0, stall}, 32'(EXP_MDU_START));
        tick();
        e_md_start = 1'b0; e_md_is_div = 1'b0;
        mdu_after = 0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (!stall) break;
            mdu_after++;
            tick();
        end
        check_eq("t6_busy_cycles", 32'(mdu_after), 32'(EXP_MDU_AFTER));
        check_eq("t6_released", {31'd0, stall}, 32'd0);
        check_eq("t6_cnt", stall_cnt, 32'(EXP_MDU_START + EXP_MDU_AFTER));
        tick();
        nop();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
